// File: rtl/verificador_disjuncao_if.sv
// Handshake and result bundle between the disjunction sequencer and its
// driver. The sequencer uses slave; whatever closes the loop uses master.
interface verificador_disjuncao_if #(
  parameter int ERR_W = 3
);
  logic             start;
  logic             s_in;
  logic             a_out;
  logic             b_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic             mismatch;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       vec_idx;

  modport master (
    output start, s_in,
    input  a_out, b_out, busy, done, pass, mismatch, err_count, vec_idx
  );

  modport slave (
    input  start, s_in,
    output a_out, b_out, busy, done, pass, mismatch, err_count, vec_idx
  );
endinterface

// File: rtl/verificador_disjuncao.sv
// Clocked stimulus-and-check sequencer for the (a | ~b) disjunction block:
// sweeps the four input vectors, samples s_in after a settle time and counts mismatches.
module verificador_disjuncao #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 3
) (
  input logic                clk,
  input logic                rst_n,
  verificador_disjuncao_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);

  // Index-to-vector mapping gives the order (0,0), (1,1), (0,1), (1,0).
  function automatic logic vec_a(input logic [1:0] idx);
    return idx[0];
  endfunction

  function automatic logic vec_b(input logic [1:0] idx);
    return idx[0] ^ idx[1];
  endfunction

  function automatic logic expected_s(input logic a, input logic b);
    return a | ~b;
  endfunction

  state_t           state_r, state_s;
  logic [3:0]       cnt_r, cnt_s;
  logic [1:0]       vec_r, vec_s;
  logic             a_r, a_s;
  logic             b_r, b_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             pass_r, pass_s;
  logic             mism_r, mism_s;
  logic [ERR_W-1:0] err_r, err_s;

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      vec_r   <= 2'd0;
      a_r     <= 1'b0;
      b_r     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      mism_r  <= 1'b0;
      err_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      vec_r   <= vec_s;
      a_r     <= a_s;
      b_r     <= b_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
      mism_r  <= mism_s;
      err_r   <= err_s;
    end
  end

  // Next-state and next-output logic; pulses default low, everything else holds.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    vec_s   = vec_r;
    a_s     = a_r;
    b_s     = b_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    pass_s  = pass_r;
    mism_s  = 1'b0;
    err_s   = err_r;

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          vec_s   = 2'd0;
          a_s     = vec_a(2'd0);
          b_s     = vec_b(2'd0);
          err_s   = '0;
          pass_s  = 1'b0;
          cnt_s   = SETTLE_LOAD;
          busy_s  = 1'b1;
          state_s = SETTLE;
        end else begin
          state_s = IDLE;
        end
      end

      SETTLE: begin
        if (cnt_r == 4'd0) begin
          state_s = SAMPLE;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end

      SAMPLE: begin
        if (bus.s_in != expected_s(a_r, b_r)) begin
          mism_s = 1'b1;
          if (err_r != ERR_MAX) begin
            err_s = err_r + ERR_ONE;
          end else begin
            err_s = err_r;
          end
        end else begin
          mism_s = 1'b0;
        end

        if (vec_r == 2'd3) begin
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = DONE;
        end else begin
          vec_s   = vec_r + 2'd1;
          a_s     = vec_a(vec_r + 2'd1);
          b_s     = vec_b(vec_r + 2'd1);
          cnt_s   = SETTLE_LOAD;
          state_s = SETTLE;
        end
      end

      DONE: begin
        // err_r already includes any mismatch from the last SAMPLE edge.
        pass_s  = (err_r == '0);
        busy_s  = 1'b0;
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  assign bus.a_out     = a_r;
  assign bus.b_out     = b_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;
  assign bus.mismatch  = mism_r;
  assign bus.err_count = err_r;
  assign bus.vec_idx   = vec_r;

endmodule

// File: tb/tb_verificador_disjuncao.sv
// Self-checking bench: three sequencer instances (default, long settle, 1-bit counter)
// closed over a truth-table model of the disjunction block.
module tb_verificador_disjuncao;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  verificador_disjuncao_if #(.ERR_W(3)) if1 ();
  verificador_disjuncao_if #(.ERR_W(3)) if2 ();
  verificador_disjuncao_if #(.ERR_W(1)) if3 ();

  verificador_disjuncao #(.SETTLE_CYCLES(1), .ERR_W(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  verificador_disjuncao #(.SETTLE_CYCLES(4), .ERR_W(3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  verificador_disjuncao #(.SETTLE_CYCLES(1), .ERR_W(1)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  // Response tables indexed by {a,b}; 4'b1101 is the real (a | ~b) block.
  logic [3:0] resp1 = 4'b1101;
  logic [3:0] resp2 = 4'b1101;
  logic [3:0] resp3 = 4'b1101;
  logic       glitch2 = 1'b0;

  assign if1.s_in = resp1[{if1.a_out, if1.b_out}];
  assign if2.s_in = resp2[{if2.a_out, if2.b_out}] ^ glitch2;
  assign if3.s_in = resp3[{if3.a_out, if3.b_out}];

  int tests = 0;
  int fails = 0;

  logic [1:0] seq [4];

  typedef struct {
    logic [3:0] resp;
    int         err;
    logic       pass;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic ref_s(input logic [1:0] ab);
    return ab[1] | ~ab[0];
  endfunction

  function automatic int model_errs(input logic [3:0] r, input int max_cnt);
    int n = 0;
    for (int j = 0; j < 4; j++) begin
      if (r[seq[j]] != ref_s(seq[j])) n++;
    end
    return (n > max_cnt) ? max_cnt : n;
  endfunction

  // One full sweep on dut1 with cycle-exact checks of vectors, pulses and results.
  task automatic sweep1(input logic [3:0] r, input int exp_err, input logic exp_pass);
    resp1 = r;
    @(negedge clk);
    if1.start = 1'b1;
    @(posedge clk);
    #1 if1.start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      chk("vec_a",    {31'd0, if1.a_out}, {31'd0, seq[j][1]});
      chk("vec_b",    {31'd0, if1.b_out}, {31'd0, seq[j][0]});
      chk("vec_idx",  {30'd0, if1.vec_idx}, j);
      chk("busy",     {31'd0, if1.busy}, 32'd1);
      chk("mism_low", {31'd0, if1.mismatch}, 32'd0);
      @(posedge clk); #1;
      chk("mismatch", {31'd0, if1.mismatch}, {31'd0, (r[seq[j]] != ref_s(seq[j]))});
    end
    chk("done_pulse", {31'd0, if1.done}, 32'd1);
    chk("busy_done",  {31'd0, if1.busy}, 32'd0);
    chk("a_hold",     {30'd0, if1.a_out, if1.b_out}, 32'd2);
    @(posedge clk); #1;
    chk("done_end",   {31'd0, if1.done}, 32'd0);
    chk("err_count",  {29'd0, if1.err_count}, exp_err);
    chk("pass",       {31'd0, if1.pass}, {31'd0, exp_pass});
  endtask

  // Counts edges from the start edge until done rises on dut3; -1 on timeout.
  task automatic sweep3(input logic [3:0] r, output int lat);
    resp3 = r;
    lat = -1;
    @(negedge clk);
    if3.start = 1'b1;
    @(posedge clk);
    #1 if3.start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (if3.done) begin
        lat = k;
        break;
      end
    end
  endtask

  int lat, first_done, second_done, idx_seen;
  logic [3:0] rr;

  initial begin
    seq[0] = 2'b00; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b10;
    tbl[0] = '{4'b1101, 0, 1'b1};
    tbl[1] = '{4'b0000, 3, 1'b0};
    tbl[2] = '{4'b0010, 4, 1'b0};
    tbl[3] = '{4'b1111, 1, 1'b0};
    tbl[4] = '{4'b0111, 2, 1'b0};

    if1.start = 1'b0; if2.start = 1'b0; if3.start = 1'b0;

    // Reset with start asserted: reset must win.
    rst_n = 1'b0;
    if1.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  {31'd0, if1.busy}, 32'd0);
    chk("rst_done",  {31'd0, if1.done}, 32'd0);
    chk("rst_pass",  {31'd0, if1.pass}, 32'd0);
    chk("rst_mism",  {31'd0, if1.mismatch}, 32'd0);
    chk("rst_err",   {29'd0, if1.err_count}, 32'd0);
    chk("rst_idx",   {30'd0, if1.vec_idx}, 32'd0);
    chk("rst_ab",    {30'd0, if1.a_out, if1.b_out}, 32'd0);
    if1.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Fixed table of response behaviours.
    for (int i = 0; i < 5; i++) begin
      sweep1(tbl[i].resp, tbl[i].err, tbl[i].pass);
      repeat (2) @(posedge clk);
    end

    // Randomised response tables against the model.
    for (int i = 0; i < 8; i++) begin
      rr = 4'($urandom_range(0, 15));
      sweep1(rr, model_errs(rr, 7), (model_errs(rr, 7) == 0));
      repeat (1) @(posedge clk);
    end

    // Reset in the middle of vector 2 after errors have accumulated.
    resp1 = 4'b0000;
    @(negedge clk);
    if1.start = 1'b1;
    @(posedge clk);
    #1 if1.start = 1'b0;
    idx_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (if1.vec_idx == 2'd2) begin
        idx_seen = 1;
        break;
      end
    end
    chk("reach_vec2", idx_seen, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", {31'd0, if1.busy}, 32'd0);
    chk("mid_idx",  {30'd0, if1.vec_idx}, 32'd0);
    chk("mid_ab",   {30'd0, if1.a_out, if1.b_out}, 32'd0);
    chk("mid_err",  {29'd0, if1.err_count}, 32'd0);
    chk("mid_done", {31'd0, if1.done}, 32'd0);
    @(posedge clk); #1;
    chk("mid_done2", {31'd0, if1.done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    sweep1(4'b1101, 0, 1'b1);

    // Start re-asserted while busy: no restart, done stays at 8 edges.
    @(negedge clk);
    if1.start = 1'b1;
    @(posedge clk);
    #1 if1.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      if (k == 3) if1.start = 1'b1;
      if (k == 6) if1.start = 1'b0;
      @(posedge clk); #1;
      if (if1.done) begin
        lat = k;
        break;
      end
    end
    chk("busy_start_lat", lat, 32'd8);
    repeat (2) @(posedge clk); #1;
    chk("no_restart", {31'd0, if1.busy}, 32'd0);

    // Start held high: second sweep starts right after returning to IDLE.
    @(negedge clk);
    if1.start = 1'b1;
    @(posedge clk);
    first_done = -1; second_done = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 10) chk("held_busy", {31'd0, if1.busy}, 32'd1);
      if (if1.done) begin
        if (first_done < 0) begin
          first_done = k;
        end else begin
          second_done = k;
          if1.start = 1'b0;
          break;
        end
      end
    end
    if1.start = 1'b0;
    chk("held_first",  first_done, 32'd8);
    chk("held_second", second_done, 32'd18);
    @(posedge clk); #1;
    chk("held_pass", {31'd0, if1.pass}, 32'd1);
    repeat (2) @(posedge clk); #1;
    chk("held_idle", {31'd0, if1.busy}, 32'd0);

    // Long settle: 5 cycles per vector, s_in toggled during SETTLE only.
    @(negedge clk);
    if2.start = 1'b1;
    @(posedge clk);
    #1 if2.start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      glitch2 = ((k % 5) != 4);
      chk("s4_ab",   {30'd0, if2.a_out, if2.b_out}, {30'd0, seq[k / 5]});
      chk("s4_mism", {31'd0, if2.mismatch}, 32'd0);
      chk("s4_err",  {29'd0, if2.err_count}, 32'd0);
      @(posedge clk); #1;
      if (k < 19) chk("s4_nodone", {31'd0, if2.done}, 32'd0);
    end
    glitch2 = 1'b0;
    chk("s4_done", {31'd0, if2.done}, 32'd1);
    chk("s4_mism_last", {31'd0, if2.mismatch}, 32'd0);
    @(posedge clk); #1;
    chk("s4_pass", {31'd0, if2.pass}, 32'd1);
    chk("s4_errf", {29'd0, if2.err_count}, 32'd0);

    // One-bit counter: inverted block saturates at 1.
    sweep3(4'b0010, lat);
    chk("w1_lat", lat, 32'd8);
    chk("w1_err", {31'd0, if3.err_count}, 32'd1);
    @(posedge clk); #1;
    chk("w1_pass", {31'd0, if3.pass}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rr = 4'($urandom_range(0, 15));
      sweep3(rr, lat);
      chk("w1r_lat", lat, 32'd8);
      chk("w1r_err", {31'd0, if3.err_count}, model_errs(rr, 1));
      @(posedge clk); #1;
      chk("w1r_pass", {31'd0, if3.pass}, {31'd0, (model_errs(rr, 1) == 0)});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/verificador_disjuncao.md
Name: verificador_disjuncao

Overview:
- Sequential stimulus-and-check stage wrapped around the combinational `(a | ~b)` NOR-only disjunction block.
- On a start pulse, the block drives the four input combinations onto the disjunction's `a`/`b` inputs.
- After a programmable settle time it samples the returned `s` for each combination and compares it with the expected value.
- It counts mismatches and reports pass or fail. It replaces the hand-written `#1` stimulus used in the example benches with a synthesizable, clocked sequencer.

Parameters:
- SETTLE_CYCLES, 1, cycles between driving a vector and sampling `s_in`. Legal range is 1..15.
- ERR_W, 3, width of the saturating mismatch counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  starts one sweep; sampled only in IDLE.
- s_in  input  1  result `s` from the disjunction block.
- a_out  output  1  drives disjunction input `a`.
- b_out  output  1  drives disjunction input `b`.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  1 when the last completed sweep had zero mismatches; held until the next start.
- mismatch  output  1  one-cycle pulse when the sampled `s_in` differs from the expected value.
- err_count  output  ERR_W  mismatches in the current or last sweep; saturates at 2^ERR_W-1.
- vec_idx  output  2  index of the vector currently driven.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (`clk`, `rst_n`). Reset is sampled on the rising edge of `clk`.
- Reset values: state=IDLE, a_out=0, b_out=0, busy=0, done=0, pass=0, mismatch=0, err_count=0, vec_idx=0, settle counter=0.
- Vector order and mapping:
  - a_out = vec_idx[0]; b_out = vec_idx[0]^vec_idx[1].
  - The sequence is therefore (a,b) = (0,0), (1,1), (0,1), (1,0).
  - Expected value: exp = a_out | ~b_out, giving 1, 1, 0, 1.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - If start=1: vec_idx<=0, a_out/b_out<=vector 0, err_count<=0, pass<=0, settle counter<=SETTLE_CYCLES-1, go to SETTLE.
  - Otherwise hold all outputs.
- SETTLE: when the settle counter is 0, go to SAMPLE; otherwise decrement it. Total time in SETTLE is SETTLE_CYCLES cycles.
- SAMPLE (one cycle): on the exit edge, compare s_in with exp.
  - If they differ: mismatch<=1 for one cycle, and err_count<=err_count+1 unless already all-ones (saturate, no wrap).
  - If vec_idx==3: go to DONE.
  - Otherwise: vec_idx<=vec_idx+1, a_out/b_out<=next vector, settle counter reloads, go to SETTLE.
- DONE (one cycle):
  - done=1.
  - pass<=(err_count==0), accounting for a mismatch registered on the final SAMPLE edge.
  - Return to IDLE.
  - a_out/b_out hold the last vector (1,0) until the next start.
- busy=1 in SETTLE and SAMPLE; 0 in IDLE and DONE.
- Latency with SETTLE_CYCLES=1:
  - Start is accepted at edge E0.
  - Vector j is compared at edge E0+2(j+1).
  - DONE is entered at E8, done is high for the cycle E8–E9, and IDLE is re-entered at E9.
  - General case: each vector takes SETTLE_CYCLES+1 cycles.
- Boundary conditions:
  - start while busy or in DONE: ignored, with no restart or effect.
  - start held high continuously: a new sweep begins on the first IDLE cycle after DONE.
  - rst_n=0 mid-sweep: immediate return to reset values on that edge; no done pulse.
  - rst_n=0 and start=1 on the same edge: reset wins.
  - s_in is sampled only in SAMPLE; glitches in other states are ignored.
  - vec_idx never exceeds 3 and does not wrap within a sweep.

Test Plan:
- Correct DUT (disjuncao connected), SETTLE_CYCLES=1, start pulse at cycle 2:
  - a/b sequence is 00, 11, 01, 10.
  - No mismatch pulses; done pulses exactly 8 cycles after start is accepted; pass=1; err_count=0.
- Faulty DUT with s_in forced to 0:
  - mismatch pulses on vectors 0, 1, 3.
  - err_count=3; pass=0 after done.
- ERR_W=1 with s_in inverted against the correct DUT: err_count saturates at 1 (no wrap); pass=0.
- SETTLE_CYCLES=4: each vector is held 5 cycles; done comes 20 cycles after the start edge.
  - Toggle s_in during SETTLE with no effect on err_count.
- Reset mid-operation: rst_n=0 at vector 2.
  - Next edge: busy=0, vec_idx=0, a_out=b_out=0, err_count=0, no done pulse.
  - A fresh start then completes with pass=1.
- Start re-asserted while busy: no restart, and done occurs at the original time.
  - Start held high through DONE launches a second sweep immediately after return to IDLE.
